// File: rtl/safelock_controller_if.sv
// Keypad/lock bundle between the safelock front panel and its sequencing controller.
interface safelock_controller_if;
    logic       i_digit_valid;
    logic [3:0] i_digit;
    logic       i_lock;
    logic       i_set_req;
    logic [2:0] o_state;
    logic       o_unlock;
    logic       o_alarm;
    logic [2:0] o_digit_cnt;
    logic [2:0] o_attempts;

    // Front panel: drives keypad/lock requests, observes status
    modport master (
        output i_digit_valid, i_digit, i_lock, i_set_req,
        input  o_state, o_unlock, o_alarm, o_digit_cnt, o_attempts
    );

    // Controller: consumes requests, drives status
    modport slave (
        input  i_digit_valid, i_digit, i_lock, i_set_req,
        output o_state, o_unlock, o_alarm, o_digit_cnt, o_attempts
    );
endinterface

// File: rtl/safelock_controller.sv
// Safelock sequencing FSM: collects keypad digits, checks them against the stored
// code and drives lock, alarm and attempt-count status. All outputs are registered.
module safelock_controller #(
    parameter int unsigned           CODE_LEN       = 4,
    parameter int unsigned           MAX_ATTEMPTS   = 3,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned           ENTRY_TIMEOUT  = 1000,
    parameter int unsigned           ERR_CYCLES     = 500,
    parameter int unsigned           LOCKOUT_CYCLES = 5000
) (
    input logic                  i_clk,
    input logic                  i_rst,
    safelock_controller_if.slave bus
);
    localparam int unsigned CW    = 4 * CODE_LEN;
    localparam int unsigned T_A   = (ENTRY_TIMEOUT > ERR_CYCLES) ? ENTRY_TIMEOUT : ERR_CYCLES;
    localparam int unsigned T_MAX = (T_A > LOCKOUT_CYCLES) ? T_A : LOCKOUT_CYCLES;
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        LOCKED  = 3'd0,
        ENTRY   = 3'd1,
        OPEN    = 3'd2,
        ERROR   = 3'd3,
        ALARM   = 3'd4,
        SETCODE = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [2:0]      digit_cnt, digit_cnt_n;
    logic [2:0]      attempts, attempts_n;
    logic [CW-1:0]   shreg, shreg_n;
    logic [CW-1:0]   code, code_n;
    logic            unlock, unlock_n;
    logic            alarm, alarm_n;

    logic            digit_ok;
    logic            expired;
    logic            last_digit;
    logic [CW-1:0]   shifted;
    logic [2:0]      attempts_inc;

    // Dwell/idle budget loaded on entry to a state; counter expires when it reaches 0,
    // so a load of N-1 gives exactly N cycles in the state.
    function automatic logic [TW-1:0] reload(input state_t s);
        case (s)
            ENTRY, SETCODE: reload = TW'(ENTRY_TIMEOUT - 1);
            ERROR:          reload = TW'(ERR_CYCLES - 1);
            ALARM:          reload = TW'(LOCKOUT_CYCLES - 1);
            default:        reload = '0;
        endcase
    endfunction

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= LOCKED;
            timer     <= '0;
            digit_cnt <= '0;
            attempts  <= '0;
            shreg     <= '0;
            code      <= DEFAULT_CODE;
            unlock    <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            digit_cnt <= digit_cnt_n;
            attempts  <= attempts_n;
            shreg     <= shreg_n;
            code      <= code_n;
            unlock    <= unlock_n;
            alarm     <= alarm_n;
        end
    end

    // Next-state, timer, digit collection and registered-output decode
    always_comb begin
        digit_ok     = bus.i_digit_valid && (bus.i_digit <= 4'd9);
        expired      = (timer == '0);
        last_digit   = (digit_cnt == 3'(CODE_LEN - 1));
        shifted      = {shreg[CW-5:0], bus.i_digit};
        attempts_inc = (attempts == 3'(MAX_ATTEMPTS)) ? attempts : attempts + 3'd1;

        state_n     = state;
        timer_n     = expired ? '0 : timer - TW'(1);
        digit_cnt_n = digit_cnt;
        attempts_n  = attempts;
        shreg_n     = shreg;
        code_n      = code;

        case (state)
            LOCKED: begin
                if (digit_ok) begin
                    state_n     = ENTRY;
                    shreg_n     = shifted;
                    digit_cnt_n = 3'd1;
                end
            end
            ENTRY: begin
                // Expiry is checked first so a digit on the expiry cycle is dropped
                if (expired) begin
                    state_n     = LOCKED;
                    digit_cnt_n = '0;
                end else if (digit_ok) begin
                    if (last_digit) begin
                        digit_cnt_n = '0;
                        if (shifted == code) begin
                            state_n    = OPEN;
                            attempts_n = '0;
                        end else begin
                            attempts_n = attempts_inc;
                            state_n    = (attempts_inc == 3'(MAX_ATTEMPTS)) ? ALARM : ERROR;
                        end
                    end else begin
                        shreg_n     = shifted;
                        digit_cnt_n = digit_cnt + 3'd1;
                        timer_n     = reload(ENTRY);
                    end
                end
            end
            OPEN: begin
                if (bus.i_lock) begin
                    state_n = LOCKED;
                end else if (bus.i_set_req) begin
                    state_n     = SETCODE;
                    digit_cnt_n = '0;
                end
            end
            SETCODE: begin
                if (bus.i_lock) begin
                    state_n     = LOCKED;
                    digit_cnt_n = '0;
                end else if (expired) begin
                    state_n     = OPEN;
                    digit_cnt_n = '0;
                end else if (digit_ok) begin
                    if (last_digit) begin
                        code_n      = shifted;
                        state_n     = OPEN;
                        digit_cnt_n = '0;
                    end else begin
                        shreg_n     = shifted;
                        digit_cnt_n = digit_cnt + 3'd1;
                        timer_n     = reload(SETCODE);
                    end
                end
            end
            ERROR: begin
                if (expired) state_n = LOCKED;
            end
            ALARM: begin
                if (expired) begin
                    state_n    = LOCKED;
                    attempts_n = '0;
                end
            end
            default: begin
                state_n     = LOCKED;
                digit_cnt_n = '0;
            end
        endcase

        if (state_n != state) timer_n = reload(state_n);

        unlock_n = (state_n == OPEN) || (state_n == SETCODE);
        alarm_n  = (state_n == ALARM);
    end

    // Status outputs straight from registers
    assign bus.o_state     = state;
    assign bus.o_unlock    = unlock;
    assign bus.o_alarm     = alarm;
    assign bus.o_digit_cnt = digit_cnt;
    assign bus.o_attempts  = attempts;
endmodule

// File: tb/tb_safelock_controller.sv
// Directed testbench for safelock_controller with short timers.
// Observation word layout: {state[2:0], unlock, alarm, digit_cnt[2:0], attempts[2:0]}.
module tb_safelock_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [10:0] exp_v;

    safelock_controller_if bus ();

    safelock_controller #(
        .CODE_LEN       (4),
        .MAX_ATTEMPTS   (3),
        .DEFAULT_CODE   (16'h1234),
        .ENTRY_TIMEOUT  (8),
        .ERR_CYCLES     (4),
        .LOCKOUT_CYCLES (10)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] snap();
        return {bus.o_state, bus.o_unlock, bus.o_alarm, bus.o_digit_cnt, bus.o_attempts};
    endfunction

    function automatic logic [10:0] pack(input int st, input int ul, input int al,
                                         input int cnt, input int att);
        return {3'(st), 1'(ul), 1'(al), 3'(cnt), 3'(att)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic [3:0] d);
        bus.i_digit_valid = 1'b1;
        bus.i_digit       = d;
        tick();
        bus.i_digit_valid = 1'b0;
        bus.i_digit       = 4'd0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        press(c[15:12]);
        press(c[11:8]);
        press(c[7:4]);
        press(c[3:0]);
    endtask

    task automatic pulse_lock();
        bus.i_lock = 1'b1;
        tick();
        bus.i_lock = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_v = pack(0, 0, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL reset got=%b exp=%b", snap(), exp_v); end
    endtask

    task automatic test_correct_code();
        press(4'd1);
        exp_v = pack(1, 0, 0, 1, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL correct_first got=%b exp=%b", snap(), exp_v); end
        press(4'd2);
        press(4'd3);
        exp_v = pack(1, 0, 0, 3, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL correct_third got=%b exp=%b", snap(), exp_v); end
        press(4'd4);
        exp_v = pack(2, 1, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL correct_open got=%b exp=%b", snap(), exp_v); end
        pulse_lock();
        exp_v = pack(0, 0, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL correct_relock got=%b exp=%b", snap(), exp_v); end
    endtask

    task automatic test_wrong_code();
        enter_code(16'h1235);
        exp_v = pack(3, 0, 0, 0, 1); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL wrong_error got=%b exp=%b", snap(), exp_v); end
        press(4'd1);
        idle(2);
        exp_v = pack(3, 0, 0, 0, 1); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL wrong_dwell got=%b exp=%b", snap(), exp_v); end
        idle(1);
        exp_v = pack(0, 0, 0, 0, 1); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL wrong_exit got=%b exp=%b", snap(), exp_v); end
        enter_code(16'h1234);
        exp_v = pack(2, 1, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL wrong_then_open got=%b exp=%b", snap(), exp_v); end
        pulse_lock();
    endtask

    task automatic test_lockout();
        enter_code(16'h1235);
        exp_v = pack(3, 0, 0, 0, 1); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL lock_fail1 got=%b exp=%b", snap(), exp_v); end
        idle(4);
        enter_code(16'h1235);
        exp_v = pack(3, 0, 0, 0, 2); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL lock_fail2 got=%b exp=%b", snap(), exp_v); end
        idle(4);
        enter_code(16'h1235);
        exp_v = pack(4, 0, 1, 0, 3); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL lock_alarm got=%b exp=%b", snap(), exp_v); end
        press(4'd1);
        bus.i_lock = 1'b1;
        idle(8);
        bus.i_lock = 1'b0;
        exp_v = pack(4, 0, 1, 0, 3); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL lock_ignore got=%b exp=%b", snap(), exp_v); end
        idle(1);
        exp_v = pack(0, 0, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL lock_release got=%b exp=%b", snap(), exp_v); end
    endtask

    task automatic test_timeout();
        enter_code(16'h1235);
        idle(4);
        press(4'd1);
        press(4'd2);
        idle(7);
        exp_v = pack(1, 0, 0, 2, 1); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL tmo_before got=%b exp=%b", snap(), exp_v); end
        idle(1);
        exp_v = pack(0, 0, 0, 0, 1); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL tmo_expire got=%b exp=%b", snap(), exp_v); end
        press(4'hC);
        exp_v = pack(0, 0, 0, 0, 1); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL tmo_invalid_locked got=%b exp=%b", snap(), exp_v); end
        press(4'd1);
        idle(3);
        press(4'hA);
        idle(3);
        exp_v = pack(1, 0, 0, 1, 1); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL tmo_invalid_entry got=%b exp=%b", snap(), exp_v); end
        press(4'd5);
        exp_v = pack(0, 0, 0, 0, 1); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL tmo_expiry_wins got=%b exp=%b", snap(), exp_v); end
        enter_code(16'h1234);
        exp_v = pack(2, 1, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL tmo_then_open got=%b exp=%b", snap(), exp_v); end
        pulse_lock();
    endtask

    task automatic test_code_change();
        enter_code(16'h1234);
        bus.i_set_req = 1'b1;
        tick();
        bus.i_set_req = 1'b0;
        exp_v = pack(5, 1, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL set_enter got=%b exp=%b", snap(), exp_v); end
        press(4'd9);
        exp_v = pack(5, 1, 0, 1, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL set_first got=%b exp=%b", snap(), exp_v); end
        press(4'd8);
        press(4'd7);
        press(4'd6);
        exp_v = pack(2, 1, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL set_done got=%b exp=%b", snap(), exp_v); end
        pulse_lock();
        enter_code(16'h1234);
        exp_v = pack(3, 0, 0, 0, 1); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL set_old_fails got=%b exp=%b", snap(), exp_v); end
        idle(4);
        enter_code(16'h9876);
        exp_v = pack(2, 1, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL set_new_opens got=%b exp=%b", snap(), exp_v); end
        bus.i_set_req = 1'b1;
        tick();
        bus.i_set_req = 1'b0;
        press(4'd1);
        idle(7);
        exp_v = pack(5, 1, 0, 1, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL set_abort_before got=%b exp=%b", snap(), exp_v); end
        idle(1);
        exp_v = pack(2, 1, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL set_abort_open got=%b exp=%b", snap(), exp_v); end
        pulse_lock();
        enter_code(16'h9876);
        exp_v = pack(2, 1, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL set_code_kept got=%b exp=%b", snap(), exp_v); end
    endtask

    task automatic test_priority_reset();
        bus.i_lock    = 1'b1;
        bus.i_set_req = 1'b1;
        tick();
        bus.i_lock    = 1'b0;
        bus.i_set_req = 1'b0;
        exp_v = pack(0, 0, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL prio_lock_wins got=%b exp=%b", snap(), exp_v); end
        press(4'd1);
        press(4'd2);
        exp_v = pack(1, 0, 0, 2, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL prio_mid_entry got=%b exp=%b", snap(), exp_v); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_v = pack(0, 0, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL prio_reset got=%b exp=%b", snap(), exp_v); end
        enter_code(16'h9876);
        exp_v = pack(3, 0, 0, 0, 1); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL prio_custom_lost got=%b exp=%b", snap(), exp_v); end
        idle(4);
        enter_code(16'h1234);
        exp_v = pack(2, 1, 0, 0, 0); checks++;
        if (snap() !== exp_v) begin errors++; $display("FAIL prio_default_back got=%b exp=%b", snap(), exp_v); end
    endtask

    initial begin
        bus.i_digit_valid = 1'b0;
        bus.i_digit       = 4'd0;
        bus.i_lock        = 1'b0;
        bus.i_set_req     = 1'b0;
        test_reset();
        test_correct_code();
        test_wrong_code();
        test_lockout();
        test_timeout();
        test_code_change();
        test_priority_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1);
    end
endmodule
